// File: rtl/enemy_scheduler_pkg.sv
// Shared screen geometry, scheduler FSM encoding and spawn-column helper
// for the enemy scheduling slice.
package enemy_scheduler_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ENEMY_W = 48;
    localparam int XMAX    = H_RES - ENEMY_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_SPAWN  = 2'd2
    } state_t;

    // Fold a 10-bit random value into the legal column range 0..XMAX-1.
    function automatic logic [9:0] reduce_x(input logic [9:0] l);
        if (l >= 10'(XMAX)) begin
            return l - 10'(XMAX);
        end
        return l;
    endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick
// spawn columns; it never reaches the all-zero lock-up state.
module enemy_lfsr (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_o
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

// File: rtl/enemy_scheduler.sv
// Per-frame enemy slot scheduler: moves every live enemy down one step,
// retires escapees, and periodically spawns a new enemy at a random column.
module enemy_scheduler
    import enemy_scheduler_pkg::*;
#(
    parameter int N_SLOTS      = 4,
    parameter int SPAWN_PERIOD = 60,
    parameter int SPEED        = 2,
    localparam int SW          = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  hit_valid_i,
    input  logic [SW-1:0]         hit_slot_i,
    output logic [N_SLOTS-1:0]    slot_active_o,
    output logic [N_SLOTS*10-1:0] slot_x_o,
    output logic [N_SLOTS*10-1:0] slot_y_o,
    output logic                  spawn_pulse_o,
    output logic                  escape_pulse_o,
    output logic                  busy_o
);

    localparam logic [7:0] CNT_RELOAD = 8'(SPAWN_PERIOD - 1);

    state_t               r_state;
    logic [SW-1:0]        r_idx;
    logic [N_SLOTS-1:0]   r_active;
    logic [9:0]           r_x [N_SLOTS];
    logic [9:0]           r_y [N_SLOTS];
    logic [7:0]           r_cnt;
    logic                 r_spawn;
    logic                 r_escape;
    logic                 r_busy;

    logic [15:0]          w_lfsr;
    logic                 w_lfsr_unused;
    logic                 w_hit_ok;
    logic [10:0]          w_y_sum;
    logic                 w_free_found;
    logic [SW-1:0]        w_free_idx;

    enemy_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:10];
    assign w_hit_ok      = hit_valid_i && (int'(hit_slot_i) < N_SLOTS);
    assign w_y_sum       = {1'b0, r_y[r_idx]} + 11'(SPEED);

    // Lowest-index free slot wins, so scan from the top down.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_active <= '0;
            r_cnt    <= CNT_RELOAD;
            r_spawn  <= 1'b0;
            r_escape <= 1'b0;
            r_busy   <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_spawn  <= 1'b0;
            r_escape <= 1'b0;
            if (clear_i) begin
                r_state  <= ST_IDLE;
                r_idx    <= '0;
                r_active <= '0;
                r_cnt    <= CNT_RELOAD;
                r_busy   <= 1'b0;
                for (int i = 0; i < N_SLOTS; i++) begin
                    r_x[i] <= '0;
                    r_y[i] <= '0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (frame_tick_i && enable_i) begin
                            r_state <= ST_UPDATE;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_UPDATE: begin
                        if (r_active[r_idx] && !(w_hit_ok && hit_slot_i == r_idx)) begin
                            if (w_y_sum >= 11'(V_RES)) begin
                                r_active[r_idx] <= 1'b0;
                                r_escape        <= 1'b1;
                            end else begin
                                r_y[r_idx] <= w_y_sum[9:0];
                            end
                        end
                        if (r_idx == SW'(N_SLOTS - 1)) begin
                            r_state <= ST_SPAWN;
                        end else begin
                            r_idx <= r_idx + SW'(1);
                        end
                    end
                    ST_SPAWN: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (r_cnt != 8'd0) begin
                            r_cnt <= r_cnt - 8'd1;
                        end else if (w_free_found &&
                                     !(w_hit_ok && hit_slot_i == w_free_idx)) begin
                            r_active[w_free_idx] <= 1'b1;
                            r_x[w_free_idx]      <= reduce_x(w_lfsr[9:0]);
                            r_y[w_free_idx]      <= '0;
                            r_spawn              <= 1'b1;
                            r_cnt                <= CNT_RELOAD;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
                // A hit overrides whatever the FSM did to that slot this cycle.
                if (w_hit_ok) begin
                    r_active[hit_slot_i] <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_pack
            assign slot_x_o[10*gi +: 10] = r_x[gi];
            assign slot_y_o[10*gi +: 10] = r_y[gi];
        end
    endgenerate

    assign slot_active_o  = r_active;
    assign spawn_pulse_o  = r_spawn;
    assign escape_pulse_o = r_escape;
    assign busy_o         = r_busy;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench: instance A uses the default parameters, instance B spawns
// every frame so that full-slot, retry and hit-vs-escape cases are reachable.
module tb_enemy_scheduler;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        enable;
    logic        clear;
    logic        a_hit_valid;
    logic [1:0]  a_hit_slot;
    logic        b_hit_valid;
    logic [1:0]  b_hit_slot;

    logic [3:0]  a_active, b_active;
    logic [39:0] a_x, a_y, b_x, b_y;
    logic        a_spawn, a_escape, a_busy;
    logic        b_spawn, b_escape, b_busy;

    int n_vec;
    int n_fail;

    int         a_sp, a_es, b_sp, b_es, a_tot;
    logic [3:0] a_mid, b_mid;
    logic [2:0] a_bz;
    logic [9:0] exp_x;

    logic [15:0] m_lfsr, m_prev;

    enemy_scheduler u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .frame_tick_i   (frame_tick),
        .enable_i       (enable),
        .clear_i        (clear),
        .hit_valid_i    (a_hit_valid),
        .hit_slot_i     (a_hit_slot),
        .slot_active_o  (a_active),
        .slot_x_o       (a_x),
        .slot_y_o       (a_y),
        .spawn_pulse_o  (a_spawn),
        .escape_pulse_o (a_escape),
        .busy_o         (a_busy)
    );

    enemy_scheduler #(.N_SLOTS(4), .SPAWN_PERIOD(1), .SPEED(2)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .frame_tick_i   (frame_tick),
        .enable_i       (enable),
        .clear_i        (clear),
        .hit_valid_i    (b_hit_valid),
        .hit_slot_i     (b_hit_slot),
        .slot_active_o  (b_active),
        .slot_x_o       (b_x),
        .slot_y_o       (b_y),
        .spawn_pulse_o  (b_spawn),
        .escape_pulse_o (b_escape),
        .busy_o         (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value present during the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic logic [9:0] fld(input logic [39:0] v, input int i);
        return v[10*i +: 10];
    endfunction

    function automatic logic [9:0] fold(input logic [9:0] l);
        return (l >= 10'd592) ? l - 10'd592 : l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted frame: tick at the current negedge, then six cycles.
    task automatic run_frame(input int b_hit_at, input logic [1:0] b_sel,
                             input int retick_at, input int en_drop_at);
        a_sp = 0; a_es = 0; b_sp = 0; b_es = 0;
        frame_tick = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            frame_tick  = (i == retick_at);
            b_hit_valid = (i == b_hit_at);
            b_hit_slot  = b_sel;
            if (i == en_drop_at) enable = 1'b0;
            a_sp += int'(a_spawn);
            a_es += int'(a_escape);
            b_sp += int'(b_spawn);
            b_es += int'(b_escape);
            if (i == 1) a_bz[2] = a_busy;
            if (i == 5) begin
                a_bz[1] = a_busy;
                a_mid   = a_active;
                b_mid   = b_active;
            end
            if (i == 6) begin
                a_bz[0] = a_busy;
                exp_x   = fold(m_prev[9:0]);
            end
        end
        frame_tick  = 1'b0;
        b_hit_valid = 1'b0;
        enable      = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        rst = 1'b0; frame_tick = 1'b0; enable = 1'b1; clear = 1'b0;
        a_hit_valid = 1'b0; a_hit_slot = 2'd0;
        b_hit_valid = 1'b0; b_hit_slot = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_active", 32'(a_active), 32'd0);
        check("rst_x", 32'(a_x[31:0]), 32'd0);
        check("rst_y", 32'(a_y[31:0]), 32'd0);
        check("rst_spawn", 32'(a_spawn), 32'd0);
        check("rst_escape", 32'(a_escape), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Tick while disabled is not accepted.
        enable = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("disabled_tick_busy", 32'(a_busy), 32'd0);
        enable = 1'b1;

        a_tot = 0;
        for (int f = 1; f <= 4; f++) begin
            run_frame(-1, 2'd0, -1, -1);
            a_tot += a_sp;
            check($sformatf("b_spawn_f%0d", f), 32'(b_sp), 32'd1);
            if (f == 1) check("busy_trace", 32'(a_bz), 32'b110);
        end
        check("b_all_active", 32'(b_active), 32'hF);
        run_frame(-1, 2'd0, -1, -1);
        a_tot += a_sp;
        check("b_full_no_spawn", 32'(b_sp), 32'd0);
        b_hit_valid = 1'b1; b_hit_slot = 2'd2;
        @(negedge clk);
        b_hit_valid = 1'b0;
        check("b_hit_slot2", 32'(b_active), 32'b1011);
        run_frame(-1, 2'd0, -1, -1);
        a_tot += a_sp;
        check("b_retry_spawn", 32'(b_sp), 32'd1);
        check("b_retry_active", 32'(b_active), 32'hF);
        check("b_retry_y2", 32'(fld(b_y, 2)), 32'd0);
        check("b_retry_x2", 32'(fld(b_x, 2)), 32'(exp_x));
        check("b_y0_f6", 32'(fld(b_y, 0)), 32'd10);

        for (int f = 7; f <= 59; f++) begin
            run_frame(-1, 2'd0, -1, -1);
            a_tot += a_sp;
        end
        check("a_no_spawn_59", 32'(a_tot), 32'd0);
        run_frame(-1, 2'd0, -1, -1);
        check("a_spawn_f60", 32'(a_sp), 32'd1);
        check("a_active_f60", 32'(a_active), 32'b0001);
        check("a_y0_f60", 32'(fld(a_y, 0)), 32'd0);
        check("a_x0_f60", 32'(fld(a_x, 0)), 32'(exp_x));
        check("a_x0_range", 32'(fld(a_x, 0) < 10'd592), 32'd1);

        a_tot = 0;
        for (int f = 61; f <= 240; f++) begin
            run_frame(-1, 2'd0, -1, -1);
            a_tot += a_sp;
        end
        check("a_spawns_61_240", 32'(a_tot), 32'd3);
        check("a_all_active", 32'(a_active), 32'hF);

        run_frame(-1, 2'd0, -1, -1);
        check("b_escape_f241", 32'(b_es), 32'd1);
        check("b_respawn_f241", 32'(b_sp), 32'd1);
        run_frame(2, 2'd1, -1, -1);
        check("b_hit_vs_escape_pulse", 32'(b_es), 32'd0);
        check("b_hit_vs_escape_mid", 32'(b_mid[1]), 32'd0);
        check("b_hit_respawn", 32'(b_sp), 32'd1);
        check("b_y1_respawn", 32'(fld(b_y, 1)), 32'd0);

        for (int f = 243; f <= 297; f++) run_frame(-1, 2'd0, -1, -1);
        check("a_y0_f297", 32'(fld(a_y, 0)), 32'd474);
        run_frame(-1, 2'd0, -1, -1);
        check("a_y0_f298", 32'(fld(a_y, 0)), 32'd476);
        run_frame(-1, 2'd0, -1, -1);
        check("a_y0_f299", 32'(fld(a_y, 0)), 32'd478);
        check("a_act0_f299", 32'(a_active[0]), 32'd1);
        check("a_no_esc_f299", 32'(a_es), 32'd0);
        run_frame(-1, 2'd0, -1, -1);
        check("a_esc_f300", 32'(a_es), 32'd1);
        check("a_mid_act0_f300", 32'(a_mid[0]), 32'd0);
        check("a_respawn_f300", 32'(a_sp), 32'd1);
        check("a_respawn_x0", 32'(fld(a_x, 0)), 32'(exp_x));

        run_frame(-1, 2'd0, 2, -1);
        repeat (3) @(negedge clk);
        check("retick_busy", 32'(a_busy), 32'd0);
        check("retick_y0", 32'(fld(a_y, 0)), 32'd2);
        check("retick_y1", 32'(fld(a_y, 1)), 32'd362);
        run_frame(-1, 2'd0, -1, 1);
        check("en_drop_y0", 32'(fld(a_y, 0)), 32'd4);

        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_a_active", 32'(a_active), 32'd0);
        check("clear_a_x", 32'(a_x[39:8]), 32'd0);
        check("clear_a_y", 32'(a_y[39:8]), 32'd0);
        check("clear_a_busy", 32'(a_busy), 32'd0);
        check("clear_b_active", 32'(b_active), 32'd0);

        for (int f = 1; f <= 10; f++) run_frame(-1, 2'd0, -1, -1);
        check("pre_rst_b_active", 32'(b_active), 32'hF);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("pre_rst_a_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_a_busy", 32'(a_busy), 32'd0);
        check("rst_mid_b_busy", 32'(b_busy), 32'd0);
        check("rst_mid_b_active", 32'(b_active), 32'd0);
        check("rst_mid_b_y", 32'(b_y[31:0]), 32'd0);
        check("rst_mid_b_x", 32'(b_x[31:0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(a_busy), 32'd0);

        a_tot = 0;
        for (int f = 1; f <= 59; f++) begin
            run_frame(-1, 2'd0, -1, -1);
            a_tot += a_sp;
        end
        check("post_rst_no_spawn_59", 32'(a_tot), 32'd0);
        run_frame(-1, 2'd0, -1, -1);
        check("post_rst_spawn_f60", 32'(a_sp), 32'd1);
        check("post_rst_active", 32'(a_active), 32'b0001);
        check("post_rst_x0", 32'(fld(a_x, 0)), 32'(exp_x));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_scheduler.md
ENEMY_SCHEDULER -- requirements
Module: enemy_scheduler

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4: number of concurrent enemy1 instances scheduled.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 60: frames between spawn attempts (range 1..255).
REQ-003 SHALL have parameter SPEED, default 2: pixels moved downward per frame.
REQ-004 SHALL have ports as follows:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- frame_tick_i  input  1  one-cycle pulse at vblank start.
- enable_i  input  1  game running.
- clear_i  input  1  synchronous clear of all slots (game over).
- hit_valid_i  input  1  collision report strobe.
- hit_slot_i  input  2  slot index hit; width clog2(N_SLOTS).
- slot_active_o  output  N_SLOTS  per-slot active flag.
- slot_x_o  output  N_SLOTS*10  packed x positions; slot i at bits [10i+9:10i].
- slot_y_o  output  N_SLOTS*10  packed y positions; same packing.
- spawn_pulse_o  output  1  one-cycle pulse when a slot is spawned.
- escape_pulse_o  output  1  one-cycle pulse when an enemy leaves the screen.
- busy_o  output  1  high outside IDLE.

Function
REQ-005 SHALL implement FSM IDLE -> UPDATE -> SPAWN -> IDLE.
REQ-006 IDLE SHALL go to UPDATE on the cycle after frame_tick_i=1 with enable_i=1; otherwise stay in IDLE.
REQ-007 frame_tick_i arriving outside IDLE SHALL be ignored; no queuing.
REQ-008 UPDATE SHALL process slot index k=0..N_SLOTS-1, one slot per cycle, then enter SPAWN.
REQ-009 Processing an active slot SHALL compute y+SPEED in 11 bits.
  - If the result >= V_RES (480): clear active and pulse escape_pulse_o for that cycle.
  - Otherwise: store the result in y.
  - Inactive slots are unchanged.
REQ-010 SPAWN SHALL decrement spawn_cnt when nonzero; if spawn_cnt is zero at SPAWN, a spawn attempt SHALL occur. SPAWN then returns to IDLE.
REQ-011 A spawn attempt with a free slot SHALL:
  - activate the lowest-index free slot with x = spawn_x and y = 0;
  - pulse spawn_pulse_o;
  - reload spawn_cnt to SPAWN_PERIOD-1.
REQ-012 A spawn attempt with no free slot SHALL hold spawn_cnt at 0 and retry at the next frame's SPAWN.
REQ-013 spawn_x SHALL be L = lfsr[9:0], reduced as follows: if L >= XMAX (H_RES-ENEMY_W = 592), spawn_x = L-XMAX; otherwise spawn_x = L. spawn_x is always in 0..591.
REQ-014 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL advance every cycle, including while enable_i=0.
REQ-015 hit_valid_i SHALL clear slot_active_o[hit_slot_i] on the next edge in any state.
  - Hit takes priority over an UPDATE or spawn on the same slot in the same cycle; that slot stays inactive and no spawn or escape pulse is issued for it.
  - hit_slot_i >= N_SLOTS SHALL be ignored.
REQ-016 clear_i SHALL, with highest priority:
  - clear all active flags, x and y;
  - reload spawn_cnt to SPAWN_PERIOD-1;
  - force IDLE.
REQ-017 enable_i falling mid-UPDATE/SPAWN SHALL NOT abort the sequence; it only gates the next start.
REQ-018 All outputs SHALL be registered. From frame_tick_i at cycle t:
  - slot k's new y is visible at t+2+k;
  - a spawn is visible at t+2+N_SLOTS;
  - busy_o is high from t+1 through t+1+N_SLOTS.
REQ-019 x and y of an inactive slot SHALL retain their last value; consumers SHALL qualify with slot_active_o.

Reset
REQ-020 rst=0 SHALL asynchronously force:
  - state IDLE;
  - all slot_active_o, slot_x_o, slot_y_o to 0;
  - spawn_pulse_o, escape_pulse_o, busy_o to 0;
  - spawn_cnt = SPAWN_PERIOD-1;
  - lfsr = 16'hACE1.
REQ-021 Reset asserted mid-UPDATE SHALL discard partial updates; after release the block SHALL start from IDLE.
REQ-022 LFSR state SHALL never be all-zero.

Structure
REQ-023 H_RES, V_RES, ENEMY_W, ENEMY_H and the FSM state encodings SHALL live in the shared header define.v, not locally.
REQ-024 The LFSR SHALL be a sub-module enemy_lfsr with ports clk, rst and lfsr_o[15:0].
REQ-025 Slot storage SHALL be per-slot registers, not RAM; N_SLOTS cycles of UPDATE bound the latency.

Verification
REQ-026 SHALL cover these directed scenarios:
  - Reset, then 59 frame ticks with SPAWN_PERIOD=60 -> no spawn. 60th tick -> spawn_pulse_o once; slot 0 active, y=0, x<592.
  - Slot 0 at y=478, SPEED=2, frame tick -> slot 0 inactive and escape_pulse_o=1 exactly once. At y=476 -> y=478 and still active.
  - All 4 slots active, spawn due -> no spawn and spawn_cnt stays 0. Hit slot 2 -> slot 2 spawned at the next frame's SPAWN.
  - hit_valid_i with hit_slot_i=1 on the same cycle UPDATE processes slot 1 -> slot 1 inactive, no escape pulse.
  - Second frame_tick_i while busy_o=1 -> ignored; each slot's y advances by exactly SPEED per accepted tick. clear_i mid-UPDATE -> all slots 0 and IDLE next cycle.
  - rst low for 1 cycle during UPDATE -> all outputs 0 immediately; spawn_cnt=59 after release.
